// File: rtl/issue_queue.sv
// In-order dual-in/dual-out instruction buffer between decode and launch-select.
// Latency: a pushed instruction is visible on out1/out2 one cycle after capture.
// Backpressure: in_ready is low when fewer than two slots are free; then nothing is written.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int DC_W  = 67
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in1_valid,
  input  logic [PC_W-1:0]            in1_pc,
  input  logic [PC_W-1:0]            in1_npc,
  input  logic [DC_W-1:0]            in1_decodeout,
  input  logic                       in2_valid,
  input  logic [PC_W-1:0]            in2_pc,
  input  logic [PC_W-1:0]            in2_npc,
  input  logic [DC_W-1:0]            in2_decodeout,
  output logic                       in_ready,
  output logic [PC_W-1:0]            out1_pc,
  output logic [PC_W-1:0]            out1_npc,
  output logic [DC_W-1:0]            out1_decodeout,
  output logic                       receive_flag1,
  output logic [PC_W-1:0]            out2_pc,
  output logic [PC_W-1:0]            out2_npc,
  output logic [DC_W-1:0]            out2_decodeout,
  output logic                       receive_flag2,
  input  logic [3:0]                 launch_flag,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
    logic [DC_W-1:0] dc;
  } entry_t;

  entry_t          entry_q [DEPTH];
  entry_t          entry_d [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  entry_t          in1_ent;
  entry_t          in2_ent;
  entry_t          out1_ent;
  entry_t          out2_ent;
  logic            l1;
  logic            l2;

  assign in1_ent = {in1_pc, in1_npc, in1_decodeout};
  assign in2_ent = {in2_pc, in2_npc, in2_decodeout};

  // Head presentation and launch masking, all from registered state.
  always_comb begin
    receive_flag1 = (count_q != '0);
    receive_flag2 = (count_q >= CW'(2));
    in_ready      = (count_q <= CW'(DEPTH - 2));
    l1            = (launch_flag[3] | launch_flag[2]) & receive_flag1;
    l2            = (launch_flag[1] | launch_flag[0]) & receive_flag2;
    out1_ent      = receive_flag1 ? entry_q[0] : '0;
    out2_ent      = receive_flag2 ? entry_q[1] : '0;
  end

  assign out1_pc        = out1_ent.pc;
  assign out1_npc       = out1_ent.npc;
  assign out1_decodeout = out1_ent.dc;
  assign out2_pc        = out2_ent.pc;
  assign out2_npc       = out2_ent.npc;
  assign out2_decodeout = out2_ent.dc;
  assign count          = count_q;

  // Compact survivors toward entry 0, then append accepted pushes after them.
  always_comb begin
    logic [CW-1:0] pops;
    logic [CW-1:0] n_push;
    logic [CW-1:0] surv;
    logic [IW:0]   idx;
    entry_t        first;
    pops    = CW'(l1) + CW'(l2);
    n_push  = (in_ready && !flush) ? (CW'(in1_valid) + CW'(in2_valid)) : '0;
    surv    = count_q - pops;
    first   = in1_valid ? in1_ent : in2_ent;
    idx     = '0;
    count_d = surv + n_push;
    for (int i = 0; i < DEPTH; i++) begin
      // Younger-only launch keeps entry 0 and closes the hole at entry 1.
      if (l1 && l2)                idx = (IW+1)'(i) + (IW+1)'(2);
      else if (l1 || (l2 && i > 0)) idx = (IW+1)'(i) + (IW+1)'(1);
      else                          idx = (IW+1)'(i);
      entry_d[i] = (idx < (IW+1)'(DEPTH)) ? entry_q[idx[IW-1:0]] : '0;
      if (n_push != '0 && CW'(i) == surv)
        entry_d[i] = first;
      if (n_push == CW'(2) && CW'(i) == surv + CW'(1))
        entry_d[i] = in2_ent;
    end
    if (flush) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
    end
  end

  // State registers; reset clears contents as well as occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule
